// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the writeback controller.
// Holds register-write entries and load delay-line stages.
package wb_pkg;

  localparam int PW = 3;

  typedef struct packed {
    logic [PW-1:0] addr;
    logic [7:0]    dat;
    logic          zero;
    logic          ngtv;
    logic          scry;
  } wb_entry_t;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] addr;
  } ld_stage_t;

endpackage

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: upstream, memory and register-file signals
// of the writeback controller, bundled with modports.
interface wb_ctrl_if
  import wb_pkg::*;
#(
  parameter int pw = PW
);

  logic          alu_vld;
  logic [pw-1:0] alu_addr;
  logic [7:0]    alu_dat;
  logic          alu_zero;
  logic          alu_ngtv;
  logic          alu_scry;
  logic          ld_req;
  logic [pw-1:0] ld_addr;
  logic [7:0]    mem_dat;
  logic [pw-1:0] rd_addrA;
  logic [pw-1:0] rd_addrB;
  logic          wr_en;
  logic [pw-1:0] wr_addr;
  logic [7:0]    dat_out;
  logic          zero_out;
  logic          ngtv_out;
  logic          scry_out;
  logic          stall;
  logic          busy;

  modport master (
    output alu_vld, alu_addr, alu_dat,
    output alu_zero, alu_ngtv, alu_scry,
    output ld_req, ld_addr, mem_dat,
    output rd_addrA, rd_addrB,
    input  wr_en, wr_addr, dat_out,
    input  zero_out, ngtv_out, scry_out,
    input  stall, busy
  );

  modport slave (
    input  alu_vld, alu_addr, alu_dat,
    input  alu_zero, alu_ngtv, alu_scry,
    input  ld_req, ld_addr, mem_dat,
    input  rd_addrA, rd_addrB,
    output wr_en, wr_addr, dat_out,
    output zero_out, ngtv_out, scry_out,
    output stall, busy
  );

endinterface

// File: rtl/ld_delay.sv
// ld_delay: LAT-stage shift register tracking in-flight
// loads; stage LAT-1 is the one whose data returns now.
module ld_delay
  import wb_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic      clk,
  input  logic      flush,
  input  ld_stage_t din,
  output ld_stage_t stg [LAT]
);

  // shift every cycle; flush drops all in-flight loads
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else begin
      stg[0] <= din;
      for (int i = 1; i < LAT; i++) stg[i] <= stg[i-1];
    end
  end

endmodule

// File: rtl/wb_ctrl.sv
// wb_ctrl: orders ALU results and load returns onto the
// register-file write port; stalls on RAW/WAW hazards.
module wb_ctrl
  import wb_pkg::*;
#(
  parameter int pw  = PW,
  parameter int LAT = 2
) (
  input logic     clk,
  input logic     reset,
  wb_ctrl_if.slave bus
);

  ld_stage_t     stg [LAT];
  ld_stage_t     ld_in;
  ld_stage_t     fin;
  wb_entry_t     alu_e;
  wb_entry_t     ld_e;
  wb_entry_t     hold_e;
  wb_entry_t     out_e;
  logic          hold_vld;
  logic          wr_en_q;
  logic          last_scry;
  logic          hazard;
  logic          stall;
  logic          busy;
  logic          acc_alu;
  logic          acc_ld;
  logic [pw-1:0] chk [3];

  assign stall   = hold_vld | hazard;
  assign acc_alu = bus.alu_vld & ~stall;
  assign acc_ld  = bus.ld_req & ~stall;
  assign ld_in   = '{vld: acc_ld, addr: bus.ld_addr};
  assign fin     = stg[LAT-1];

  assign alu_e = '{
    addr: bus.alu_addr, dat: bus.alu_dat,
    zero: bus.alu_zero, ngtv: bus.alu_ngtv,
    scry: bus.alu_scry
  };

  assign ld_e = '{
    addr: fin.addr, dat: bus.mem_dat,
    zero: (bus.mem_dat == 8'h00),
    ngtv: bus.mem_dat[7], scry: last_scry
  };

  ld_delay #(.LAT(LAT)) u_ld_delay (
    .clk   (clk),
    .flush (reset),
    .din   (ld_in),
    .stg   (stg)
  );

  // any read or ALU dest matching an in-flight write
  always_comb begin
    chk[0] = bus.rd_addrA;
    chk[1] = bus.rd_addrB;
    chk[2] = bus.alu_addr;
    hazard = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (j < 2 || bus.alu_vld) begin
        for (int i = 0; i < LAT; i++)
          if (stg[i].vld && stg[i].addr == chk[j])
            hazard = 1'b1;
        if (hold_vld && hold_e.addr == chk[j])
          hazard = 1'b1;
        if (wr_en_q && out_e.addr == chk[j])
          hazard = 1'b1;
      end
    end
  end

  // busy while anything is still headed to the regfile
  always_comb begin
    busy = hold_vld | wr_en_q;
    for (int i = 0; i < LAT; i++)
      busy = busy | stg[i].vld;
  end

  // output register: load return > hold > ALU > idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld  <= 1'b0;
      hold_e    <= '0;
      wr_en_q   <= 1'b0;
      out_e     <= '0;
      last_scry <= 1'b0;
    end else if (fin.vld) begin
      wr_en_q   <= 1'b1;
      out_e     <= ld_e;
      last_scry <= ld_e.scry;
      if (acc_alu) begin
        hold_vld <= 1'b1;
        hold_e   <= alu_e;
      end
    end else if (hold_vld) begin
      wr_en_q   <= 1'b1;
      out_e     <= hold_e;
      last_scry <= hold_e.scry;
      hold_vld  <= 1'b0;
    end else if (acc_alu) begin
      wr_en_q   <= 1'b1;
      out_e     <= alu_e;
      last_scry <= alu_e.scry;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = out_e.addr;
  assign bus.dat_out  = out_e.dat;
  assign bus.zero_out = out_e.zero;
  assign bus.ngtv_out = out_e.ngtv;
  assign bus.scry_out = out_e.scry;
  assign bus.stall    = stall;
  assign bus.busy     = busy;

endmodule

// File: tb/tb_wb_ctrl.sv
// tb_wb_ctrl: cycle-table checks of wb_ctrl plus a
// back-to-back load sequence, LAT=2, 8 registers.
module tb_wb_ctrl;

  typedef struct {
    int rst; int av; int aa; int ad;
    int az;  int an; int ac;
    int lr;  int la; int md; int ra; int rb;
    int stl; int we; int cd; int wa; int wd;
    int wz;  int wn; int wc; int bsy;
  } vec_t;

  localparam int NV = 29;

  logic clk;
  logic reset;
  int   ncmp;
  int   nerr;
  vec_t tbl [NV];

  wb_ctrl_if #(.pw(3)) bus ();

  wb_ctrl #(.pw(3), .LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s row %0d: got %0h want %0h",
               nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    reset        = t.rst[0];
    bus.alu_vld  = t.av[0];
    bus.alu_addr = 3'(t.aa);
    bus.alu_dat  = 8'(t.ad);
    bus.alu_zero = t.az[0];
    bus.alu_ngtv = t.an[0];
    bus.alu_scry = t.ac[0];
    bus.ld_req   = t.lr[0];
    bus.ld_addr  = 3'(t.la);
    bus.mem_dat  = 8'(t.md);
    bus.rd_addrA = 3'(t.ra);
    bus.rd_addrB = 3'(t.rb);
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    // rst av aa ad az an ac lr la md ra rb
    //   | stl we cd wa wd wz wn wc bsy
    tbl[0]  = '{1,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,1,0,'h00,0,0,0,0};
    tbl[1]  = '{0,1,3,'h00,1,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[2]  = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,1,1,3,'h00,1,0,0,1};
    tbl[3]  = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[4]  = '{0,0,0,'h00,0,0,0,1,5,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[5]  = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[6]  = '{0,0,0,'h00,0,0,0,0,0,'h80,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[7]  = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,1,1,5,'h80,0,1,0,1};
    tbl[8]  = '{0,1,1,'h7f,0,0,1,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[9]  = '{0,0,0,'h00,0,0,0,1,0,'h00,6,6,
                0,1,1,1,'h7f,0,0,1,1};
    tbl[10] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[11] = '{0,1,2,'h11,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[12] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                1,1,1,0,'h00,1,0,1,1};
    tbl[13] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,1,1,2,'h11,0,0,0,1};
    tbl[14] = '{0,0,0,'h00,0,0,0,1,4,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[15] = '{0,1,4,'h55,0,0,0,0,0,'h00,6,4,
                1,0,0,0,'h00,0,0,0,1};
    tbl[16] = '{0,1,4,'h55,0,0,0,0,0,'h9c,4,6,
                1,0,0,0,'h00,0,0,0,1};
    tbl[17] = '{0,1,4,'h55,0,0,0,0,0,'h00,4,4,
                1,1,1,4,'h9c,0,1,0,1};
    tbl[18] = '{0,1,4,'h55,0,0,0,0,0,'h00,4,4,
                0,0,0,0,'h00,0,0,0,0};
    tbl[19] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,1,1,4,'h55,0,0,0,1};
    tbl[20] = '{0,1,1,'h01,0,0,1,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[21] = '{0,0,0,'h00,0,0,0,1,3,'h00,6,6,
                0,1,1,1,'h01,0,0,1,1};
    tbl[22] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[23] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[24] = '{0,0,0,'h00,0,0,0,0,0,'h00,6,6,
                0,1,1,3,'h00,1,0,1,1};
    tbl[25] = '{0,0,0,'h00,0,0,0,1,5,'h00,6,6,
                0,0,0,0,'h00,0,0,0,0};
    tbl[26] = '{1,0,0,'h00,0,0,0,0,0,'hff,6,6,
                0,0,0,0,'h00,0,0,0,1};
    tbl[27] = '{0,0,0,'h00,0,0,0,0,0,'hff,6,6,
                0,0,1,0,'h00,0,0,0,0};
    tbl[28] = '{0,0,0,'h00,0,0,0,0,0,'hff,6,6,
                0,0,1,0,'h00,0,0,0,0};

    drive(tbl[0]);
    repeat (2) @(posedge clk);

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      drive(tbl[k]);
      #1;
      chk("stall", k, 32'(bus.stall), tbl[k].stl);
      chk("wr_en", k, 32'(bus.wr_en), tbl[k].we);
      chk("busy", k, 32'(bus.busy), tbl[k].bsy);
      if (tbl[k].cd != 0) begin
        chk("wr_addr", k, 32'(bus.wr_addr), tbl[k].wa);
        chk("dat_out", k, 32'(bus.dat_out), tbl[k].wd);
        chk("zero", k, 32'(bus.zero_out), tbl[k].wz);
        chk("ngtv", k, 32'(bus.ngtv_out), tbl[k].wn);
        chk("scry", k, 32'(bus.scry_out), tbl[k].wc);
      end
    end

    // loads to regs 0..7 on consecutive cycles
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      reset        = 1'b0;
      bus.alu_vld  = 1'b0;
      bus.ld_req   = (c < 8);
      bus.ld_addr  = 3'(c);
      bus.rd_addrA = 3'(c);
      bus.rd_addrB = 3'(c);
      bus.mem_dat  = (c >= 2 && c < 10) ?
                     8'(8'h11 * (c - 1)) : 8'h00;
      #1;
      if (c < 8)
        chk("b2b_stall", 100 + c, 32'(bus.stall), 0);
      chk("b2b_wr_en", 100 + c, 32'(bus.wr_en),
          (c >= 3) ? 1 : 0);
      if (c >= 3) begin
        chk("b2b_addr", 100 + c,
            32'(bus.wr_addr), c - 3);
        chk("b2b_dat", 100 + c,
            32'(bus.dat_out), 8'(8'h11 * (c - 2)));
        chk("b2b_ngtv", 100 + c,
            32'(bus.ngtv_out), (c == 10) ? 1 : 0);
        chk("b2b_zero", 100 + c,
            32'(bus.zero_out), 0);
      end
    end

    @(negedge clk);
    bus.ld_req = 1'b0;
    #1;
    chk("b2b_idle_busy", 111, 32'(bus.busy), 0);
    chk("b2b_idle_wr_en", 111, 32'(bus.wr_en), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
